// File: rtl/adder_pkg.sv
// Shared definitions for the adder result stage.
//
// Contents:
//   WORD_W          adder word width
//   SAT_POS/SAT_NEG clamp values applied to overflowing results when
//                   ADDER_RESULT_SAT_EN is defined
//   result_entry_t  {sum, ovf, tag} view of one stored result at the
//                   default tag width
//   sat_clamp()     picks the clamp value from the wrapped sum's sign bit
package adder_pkg;

   localparam int WORD_W    = 32;
   localparam int TAG_W_DEF = 4;

   localparam logic [WORD_W-1:0] SAT_POS = 32'h7FFF_FFFF;
   localparam logic [WORD_W-1:0] SAT_NEG = 32'h8000_0000;

   typedef struct packed {
      logic [WORD_W-1:0]    sum;
      logic                 ovf;
      logic [TAG_W_DEF-1:0] tag;
   } result_entry_t;

   // On signed overflow the wrapped sign bit is the inverse of the true
   // sign: a set bit means the true result was positive.
   function automatic logic [WORD_W-1:0] sat_clamp(input logic [WORD_W-1:0] sum);
      return sum[WORD_W-1] ? SAT_POS : SAT_NEG;
   endfunction

endpackage

// File: rtl/adder_result_stage_if.sv
// Bus between the adder result stage and its surroundings.
//
// Handshake (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. The sender holds its data stable while
// valid=1 and ready=0; ready never depends combinationally on valid.
//
// Signals:
//   in_valid/in_ready/in_sum/in_ovf/in_tag     producer channel (adder side)
//   out_valid/out_ready/out_sum/out_ovf/out_tag consumer channel
//   ovf_clr                                     clear sticky flag and counter
//   ovf_sticky/ovf_cnt/level                    status readout
//
// Modports: master = producer/consumer/status side, slave = the stage.
interface adder_result_stage_if #(
   parameter int DEPTH     = 4,
   parameter int TAG_W     = 4,
   parameter int OVF_CNT_W = 8
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_sum;
   logic                 in_ovf;
   logic [TAG_W-1:0]     in_tag;

   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_sum;
   logic                 out_ovf;
   logic [TAG_W-1:0]     out_tag;

   logic                 ovf_clr;
   logic                 ovf_sticky;
   logic [OVF_CNT_W-1:0] ovf_cnt;
   logic [LVL_W-1:0]     level;

   modport master (
      output in_valid, in_sum, in_ovf, in_tag, out_ready, ovf_clr,
      input  in_ready, out_valid, out_sum, out_ovf, out_tag,
             ovf_sticky, ovf_cnt, level
   );

   modport slave (
      input  in_valid, in_sum, in_ovf, in_tag, out_ready, ovf_clr,
      output in_ready, out_valid, out_sum, out_ovf, out_tag,
             ovf_sticky, ovf_cnt, level
   );

endinterface

// File: rtl/adder_result_fifo.sv
// Storage FIFO for the adder result stage: array, wrapping pointers, level.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       write wr_data_i at the tail (caller guarantees not full)
//   wr_data_i    entry to write
//   pop_i        drop the head entry (caller guarantees not empty)
//   rd_data_o    head entry; when empty, the most recently popped entry
//                (zero after reset)
//   full_o       level == DEPTH, from registered state only
//   level_o      current occupancy
module adder_result_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 37
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [DATA_W-1:0]          wr_data_i,
   input  logic                       pop_i,
   output logic [DATA_W-1:0]          rd_data_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     level_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [DATA_W-1:0] last_q, last_d;

   // Storage needs no reset: a slot is only read while level counts it.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      last_d   = last_q;
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         last_d   = mem_q[rd_ptr_q];
      end
      case ({push_i, pop_i})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         last_q   <= last_d;
      end
   end

   // Empty shows the last popped entry so the consumer side holds its value.
   assign rd_data_o = (level_q == '0) ? last_q : mem_q[rd_ptr_q];
   assign full_o    = (level_q == LVL_W'(DEPTH));
   assign level_o   = level_q;

endmodule

// File: rtl/adder_result_stage.sv
// Registered output stage behind the 32-bit adder. Each accepted result
// (sum, overflow bit, tag) is queued in order and handed to the consumer
// over valid/ready. A sticky overflow flag and a saturating overflow event
// counter give status readout.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          adder_result_stage_if.slave (producer channel, consumer
//                channel, ovf_clr, ovf_sticky, ovf_cnt, level)
//
// Build option: define ADDER_RESULT_SAT_EN to store overflowing sums clamped
// to SAT_POS/SAT_NEG instead of the wrapped two's-complement value.
module adder_result_stage
   import adder_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int TAG_W     = 4,
   parameter int OVF_CNT_W = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   adder_result_stage_if.slave bus
);
   localparam int DATA_W = WORD_W + 1 + TAG_W;
   localparam int LVL_W  = $clog2(DEPTH) + 1;

   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 out_valid_w;
   logic [LVL_W-1:0]     level_w;
   logic [WORD_W-1:0]    store_sum;
   logic [DATA_W-1:0]    wr_data;
   logic [DATA_W-1:0]    rd_data;

   logic                 sticky_q, sticky_d;
   logic [OVF_CNT_W-1:0] cnt_q, cnt_d;

   // in_ready comes from the registered level only, so no path from out_ready.
   assign out_valid_w = (level_w != '0);
   assign push        = bus.in_valid & ~full;
   assign pop         = out_valid_w & bus.out_ready;

`ifdef ADDER_RESULT_SAT_EN
   assign store_sum = bus.in_ovf ? sat_clamp(bus.in_sum) : bus.in_sum;
`else
   assign store_sum = bus.in_sum;
`endif

   assign wr_data = {store_sum, bus.in_ovf, bus.in_tag};

   adder_result_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (push),
      .wr_data_i (wr_data),
      .pop_i     (pop),
      .rd_data_o (rd_data),
      .full_o    (full),
      .level_o   (level_w)
   );

   // A clear and an overflowing push on the same edge leave exactly that
   // one event recorded.
   always_comb begin
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (bus.ovf_clr) begin
         sticky_d = 1'b0;
         cnt_d    = '0;
      end
      if (push && bus.in_ovf) begin
         sticky_d = 1'b1;
         if (bus.ovf_clr) begin
            cnt_d = OVF_CNT_W'(1);
         end else if (cnt_q != '1) begin
            cnt_d = cnt_q + OVF_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.in_ready   = ~full;
   assign bus.out_valid  = out_valid_w;
   assign bus.out_sum    = rd_data[DATA_W-1 -: WORD_W];
   assign bus.out_ovf    = rd_data[TAG_W];
   assign bus.out_tag    = rd_data[TAG_W-1:0];
   assign bus.ovf_sticky = sticky_q;
   assign bus.ovf_cnt    = cnt_q;
   assign bus.level      = level_w;

endmodule

// File: tb/tb_adder_result_stage.sv
// Self-checking bench for adder_result_stage (DEPTH=4, TAG_W=4, OVF_CNT_W=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_adder_result_stage;
   import adder_pkg::*;

   localparam int ENT_W = 37;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   adder_result_stage_if #(.DEPTH(4), .TAG_W(4), .OVF_CNT_W(8)) bus ();

   adder_result_stage #(.DEPTH(4), .TAG_W(4), .OVF_CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   logic [ENT_W-1:0] exp_q[$];
   logic [ENT_W-1:0] obs_q[$];
   int tests_run    = 0;
   int tests_failed = 0;

   function automatic logic [31:0] model_sum(input logic [31:0] s, input logic o);
`ifdef ADDER_RESULT_SAT_EN
      if (o) return s[31] ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
      return s;
   endfunction

   // One clock: record accepted pushes as expectations and taken heads as
   // observations, then advance to the next falling edge.
   task automatic cycle();
      if (bus.in_valid && bus.in_ready)
         exp_q.push_back({model_sum(bus.in_sum, bus.in_ovf), bus.in_ovf, bus.in_tag});
      if (bus.out_valid && bus.out_ready)
         obs_q.push_back({bus.out_sum, bus.out_ovf, bus.out_tag});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.in_sum    = '0;
      bus.in_ovf    = 1'b0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;
      bus.ovf_clr   = 1'b0;
   endtask

   task automatic drive(input logic [31:0] s, input logic o, input logic [3:0] t);
      bus.in_valid = 1'b1;
      bus.in_sum   = s;
      bus.in_ovf   = o;
      bus.in_tag   = t;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tests_run++;
      if (bus.level !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_hs got level=%0d ov=%b ir=%b want 0 0 1", bus.level, bus.out_valid, bus.in_ready);
      end
      tests_run++;
      if (bus.out_sum !== 32'h0 || bus.out_ovf !== 1'b0 || bus.out_tag !== 4'h0 ||
          bus.ovf_sticky !== 1'b0 || bus.ovf_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset_out got sum=%h ovf=%b tag=%h st=%b cnt=%0d want all 0",
                  bus.out_sum, bus.out_ovf, bus.out_tag, bus.ovf_sticky, bus.ovf_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         drive($urandom, (i == 1), 4'(i));
         cycle();
      end
      idle();
      tests_run++;
      if (bus.level !== 3'd3 || bus.ovf_cnt !== 8'd1) begin
         tests_failed++;
         $display("FAIL prefill got level=%0d cnt=%0d want 3 1", bus.level, bus.ovf_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.level !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.ovf_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL async_reset got level=%0d ov=%b ir=%b cnt=%0d want 0 0 1 0",
                  bus.level, bus.out_valid, bus.in_ready, bus.ovf_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_fill_order();
      logic [ENT_W-1:0] e, o;
      logic [31:0] last_sum;
      int n;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive($urandom, 1'b0, 4'(i));
         cycle();
      end
      tests_run++;
      if (bus.level !== 3'd4 || bus.in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL full got level=%0d ir=%b want 4 0", bus.level, bus.in_ready);
      end
      drive(32'hDEAD_BEEF, 1'b0, 4'd4);
      cycle();
      cycle();
      tests_run++;
      if (bus.level !== 3'd4 || bus.out_valid !== 1'b1 || {bus.out_sum, bus.out_ovf, bus.out_tag} !== exp_q[0]) begin
         tests_failed++;
         $display("FAIL full_hold got level=%0d head=%h want 4 %h", bus.level,
                  {bus.out_sum, bus.out_ovf, bus.out_tag}, exp_q[0]);
      end
      idle();
      last_sum = exp_q[3][36:5];
      bus.out_ready = 1'b1;
      cycle();
      tests_run++;
      if (bus.in_ready !== 1'b1 || bus.level !== 3'd3) begin
         tests_failed++;
         $display("FAIL pop_from_full got ir=%b level=%0d want 1 3", bus.in_ready, bus.level);
      end
      repeat (4) cycle();
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.level !== 3'd0 || bus.out_sum !== last_sum || bus.out_tag !== 4'd3) begin
         tests_failed++;
         $display("FAIL empty_hold got ov=%b level=%0d sum=%h tag=%0d want 0 0 %h 3",
                  bus.out_valid, bus.level, bus.out_sum, bus.out_tag, last_sum);
      end
      tests_run++;
      if (obs_q.size() != 4 || exp_q.size() != 4) begin
         tests_failed++;
         $display("FAIL fill_count got obs=%0d exp=%0d want 4 4", obs_q.size(), exp_q.size());
      end
      n = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         tests_run++;
         if (o !== e || o[3:0] !== 4'(n)) begin
            tests_failed++;
            $display("FAIL fill_order[%0d] got %h want %h (tag %0d)", n, o, e, n);
         end
         n++;
      end
      exp_q.delete();
      obs_q.delete();
      idle();
   endtask

   task automatic test_back_to_back();
      logic [ENT_W-1:0] e, o;
      int bad_level = 0;
      drive($urandom, 1'b0, 4'd0);
      cycle();
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         drive($urandom, 1'b0, 4'(i));
         cycle();
         if (bus.level !== 3'd1) bad_level++;
      end
      tests_run++;
      if (bad_level != 0) begin
         tests_failed++;
         $display("FAIL stream_level got %0d cycles off level 1 want 0", bad_level);
      end
      bus.in_valid = 1'b0;
      cycle();
      tests_run++;
      if (obs_q.size() != 21 || exp_q.size() != 21 || bus.level !== 3'd0) begin
         tests_failed++;
         $display("FAIL stream_count got obs=%0d exp=%0d level=%0d want 21 21 0",
                  obs_q.size(), exp_q.size(), bus.level);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL stream_data got %h want %h", o, e);
         end
      end
      exp_q.delete();
      obs_q.delete();
      idle();
   endtask

   task automatic test_overflow();
      logic [31:0] want1, want2;
      logic [ENT_W-1:0] e, o;
`ifdef ADDER_RESULT_SAT_EN
      want1 = 32'h7FFF_FFFF;
      want2 = 32'h8000_0000;
`else
      want1 = 32'h8000_0000;
      want2 = 32'h7FFF_FFF0;
`endif
      drive(32'h8000_0000, 1'b1, 4'd5);
      cycle();
      idle();
      tests_run++;
      if (bus.ovf_sticky !== 1'b1 || bus.ovf_cnt !== 8'd1) begin
         tests_failed++;
         $display("FAIL ovf_first got st=%b cnt=%0d want 1 1", bus.ovf_sticky, bus.ovf_cnt);
      end
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== want1 || bus.out_ovf !== 1'b1 || bus.out_tag !== 4'd5) begin
         tests_failed++;
         $display("FAIL ovf_sum got v=%b sum=%h ovf=%b tag=%0d want 1 %h 1 5",
                  bus.out_valid, bus.out_sum, bus.out_ovf, bus.out_tag, want1);
      end
      drive(32'h7FFF_FFF0, 1'b1, 4'd6);
      cycle();
      drive(32'h0000_1234, 1'b0, 4'd7);
      cycle();
      idle();
      tests_run++;
      if (bus.ovf_cnt !== 8'd2) begin
         tests_failed++;
         $display("FAIL ovf_count got %0d want 2", bus.ovf_cnt);
      end
      bus.out_ready = 1'b1;
      cycle();
      tests_run++;
      if (bus.out_sum !== want2 || bus.out_ovf !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_neg_sum got sum=%h ovf=%b want %h 1", bus.out_sum, bus.out_ovf, want2);
      end
      repeat (3) cycle();
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL ovf_data got %h want %h", o, e);
         end
      end
      exp_q.delete();
      obs_q.delete();
      idle();
   endtask

   task automatic test_ovf_clr();
      bus.out_ready = 1'b1;
      drive($urandom, 1'b1, 4'd9);
      bus.ovf_clr = 1'b1;
      cycle();
      tests_run++;
      if (bus.ovf_sticky !== 1'b1 || bus.ovf_cnt !== 8'd1) begin
         tests_failed++;
         $display("FAIL clr_push_wins got st=%b cnt=%0d want 1 1", bus.ovf_sticky, bus.ovf_cnt);
      end
      bus.in_valid = 1'b0;
      cycle();
      tests_run++;
      if (bus.ovf_sticky !== 1'b0 || bus.ovf_cnt !== 8'd0) begin
         tests_failed++;
         $display("FAIL clr_alone got st=%b cnt=%0d want 0 0", bus.ovf_sticky, bus.ovf_cnt);
      end
      exp_q.delete();
      obs_q.delete();
      idle();
      cycle();
   endtask

   task automatic test_saturation();
      logic [ENT_W-1:0] e, o;
      int bad = 0;
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         drive($urandom, 1'b1, 4'(i));
         cycle();
         if (i == 100) begin
            tests_run++;
            if (bus.ovf_cnt !== 8'd100) begin
               tests_failed++;
               $display("FAIL sat_mid got %0d want 100", bus.ovf_cnt);
            end
         end
         if (i == 255) begin
            tests_run++;
            if (bus.ovf_cnt !== 8'd255) begin
               tests_failed++;
               $display("FAIL sat_reach got %0d want 255", bus.ovf_cnt);
            end
         end
      end
      tests_run++;
      if (bus.ovf_cnt !== 8'd255 || bus.ovf_sticky !== 1'b1) begin
         tests_failed++;
         $display("FAIL sat_hold got cnt=%0d st=%b want 255 1", bus.ovf_cnt, bus.ovf_sticky);
      end
      bus.in_valid = 1'b0;
      cycle();
      tests_run++;
      if (obs_q.size() != 300 || exp_q.size() != 300) begin
         tests_failed++;
         $display("FAIL sat_count got obs=%0d exp=%0d want 300 300", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (o !== e) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL sat_data got %0d wrong entries want 0", bad);
      end
      exp_q.delete();
      obs_q.delete();
      idle();
   endtask

   initial begin
      test_reset();
      test_fill_order();
      test_back_to_back();
      test_overflow();
      test_ovf_clr();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
